// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the latch bundle carried between stages.
package pipe_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // One pipeline slot: valid, register write-enable, destination and result.
  typedef struct packed {
    logic            valid;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wdata;
  } wb_bundle_t;
endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: 2 combinational read ports, 1 write port,
// single-edge synchronous clear, x0 hardwired to zero, write-through bypass.
module regfile_2r1w
  import pipe_pkg::*;
#(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int NREG  = pipe_pkg::NREG,
  parameter int AW    = pipe_pkg::AW,
  parameter int NRP   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [XLEN-1:0]           wdata,
  input  logic                      byp_en,
  input  logic [AW-1:0]             byp_addr,
  input  logic [XLEN-1:0]           byp_data,
  input  logic [NRP-1:0][AW-1:0]    raddr,
  output logic [NRP-1:0][XLEN-1:0]  rdata
);
  logic [NREG-1:0][XLEN-1:0] regs;

  // Array update: clear everything on reset, never store into x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Each read port resolves independently: x0, then bypass, then array.
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    always_comb begin
      rdata[p] = regs[raddr[p]];
      if (raddr[p] == '0) begin
        rdata[p] = '0;
      end else if (byp_en && (byp_addr == raddr[p])) begin
        rdata[p] = byp_data;
      end
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// MEM/WB pipeline latch with the register file it commits into.
// Widths must match the pipe_pkg constants since the latch uses wb_bundle_t.
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int NREG = pipe_pkg::NREG,
  parameter int AW   = pipe_pkg::AW,
  parameter int CW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_mem,
  input  logic            reg_we_mem,
  input  logic [AW-1:0]   rd_mem,
  input  logic [XLEN-1:0] wdata_mem,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            valid_wb,
  output logic            reg_we_wb,
  output logic [AW-1:0]   rd_wb,
  output logic [XLEN-1:0] wdata_wb,
  output logic [CW-1:0]   retire_count
);
  wb_bundle_t          wb_q;
  logic                commit;
  logic [1:0][AW-1:0]   raddr;
  logic [1:0][XLEN-1:0] rdata;

  // Reset dominates inside the sequential blocks, so it is not repeated here.
  assign commit = wb_q.valid & ~stall;

  // Latch priority: reset > stall (hold) > flush (bubble) > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else if (!stall) begin
      if (flush) begin
        wb_q <= '0;
      end else begin
        wb_q.valid <= valid_mem;
        wb_q.we    <= reg_we_mem & valid_mem;
        wb_q.rd    <= rd_mem;
        wb_q.wdata <= wdata_mem;
      end
    end
  end

  // Every committed slot retires, including x0 writes and non-writers.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= '0;
    end else if (commit) begin
      retire_count <= retire_count + 1'b1;
    end
  end

  assign raddr = {rs2_addr, rs1_addr};

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(2)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (commit & wb_q.we),
    .waddr    (wb_q.rd),
    .wdata    (wb_q.wdata),
    .byp_en   (wb_q.valid & wb_q.we),
    .byp_addr (wb_q.rd),
    .byp_data (wb_q.wdata),
    .raddr    (raddr),
    .rdata    (rdata)
  );

  assign rs1_data  = rdata[0];
  assign rs2_data  = rdata[1];
  assign valid_wb  = wb_q.valid;
  assign reg_we_wb = wb_q.we;
  assign rd_wb     = wb_q.rd;
  assign wdata_wb  = wb_q.wdata;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; small retire counter to exercise wrap.
module tb_wb_regfile;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_mem, reg_we_mem;
  logic [4:0]  rd_mem, rs1_addr, rs2_addr, rd_wb;
  logic [31:0] wdata_mem, rs1_data, rs2_data, wdata_wb;
  logic        valid_wb, reg_we_wb;
  logic [CW-1:0] retire_count;

  int n_run = 0;
  int n_fail = 0;

  wb_regfile #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_mem(valid_mem), .reg_we_mem(reg_we_mem), .rd_mem(rd_mem),
    .wdata_mem(wdata_mem), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .valid_wb(valid_wb),
    .reg_we_wb(reg_we_wb), .rd_wb(rd_wb), .wdata_wb(wdata_wb),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
    valid_mem = v; reg_we_mem = we; rd_mem = rd; wdata_mem = d;
  endtask

  task automatic rd2(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1; rs2_addr = a2;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rs1_addr = '0; rs2_addr = '0;
    step();
    rst = 1'b0;

    // Preload r1..r3, then reset must wipe them in one edge.
    mem(1'b1, 1'b1, 5'd1, 32'h11); step();
    mem(1'b1, 1'b1, 5'd2, 32'h22); step();
    mem(1'b1, 1'b1, 5'd3, 32'h33); step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);  step();
    rd2(5'd1, 5'd3);
    chk("preload_r1", rs1_data, 32'h11);
    chk("preload_cnt", 32'(retire_count), 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    rd2(5'd1, 5'd3);
    chk("rst_r1", rs1_data, 32'h0);
    chk("rst_r3", rs2_data, 32'h0);
    chk("rst_valid", 32'(valid_wb), 32'd0);
    chk("rst_wdata", wdata_wb, 32'h0);
    chk("rst_cnt", 32'(retire_count), 32'd0);

    // Basic write: bypass after edge 1, array after edge 2.
    mem(1'b1, 1'b1, 5'd5, 32'hDEADBEEF); step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd2(5'd5, 5'd6);
    chk("wr_bypass", rs1_data, 32'hDEADBEEF);
    chk("wr_other", rs2_data, 32'h0);
    chk("wr_rd_wb", 32'(rd_wb), 32'd5);
    chk("wr_cnt0", 32'(retire_count), 32'd0);
    step();
    rd2(5'd5, 5'd5);
    chk("wr_array1", rs1_data, 32'hDEADBEEF);
    chk("wr_array2", rs2_data, 32'hDEADBEEF);
    chk("wr_valid_bubble", 32'(valid_wb), 32'd0);
    chk("wr_cnt1", 32'(retire_count), 32'd1);

    // x0 write: never visible, still retires.
    mem(1'b1, 1'b1, 5'd0, 32'h1234); step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd2(5'd0, 5'd0);
    chk("x0_byp", rs1_data, 32'h0);
    chk("x0_wdata_wb", wdata_wb, 32'h1234);
    step();
    rd2(5'd0, 5'd0);
    chk("x0_arr", rs2_data, 32'h0);
    chk("x0_cnt", 32'(retire_count), 32'd2);

    // Stall: hold the slot, bypass still serves, no capture, no count.
    mem(1'b1, 1'b1, 5'd7, 32'hA5); step();
    stall = 1'b1;
    mem(1'b1, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 3; i++) begin
      step();
      rd2(5'd7, 5'd9);
      chk("stall_byp", rs1_data, 32'hA5);
      chk("stall_nocap", rs2_data, 32'h0);
      chk("stall_rd_wb", 32'(rd_wb), 32'd7);
      chk("stall_cnt", 32'(retire_count), 32'd2);
    end
    // Release with flush: the held write commits, MEM entry is dropped.
    stall = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd2(5'd7, 5'd9);
    chk("sf_r7", rs1_data, 32'hA5);
    chk("sf_r9", rs2_data, 32'h0);
    chk("sf_valid", 32'(valid_wb), 32'd0);
    chk("sf_cnt", 32'(retire_count), 32'd3);

    // Flush without stall: preload r3, then a flushed write must not land.
    mem(1'b1, 1'b1, 5'd3, 32'h3333); step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);    step();
    mem(1'b1, 1'b1, 5'd3, 32'h55); flush = 1'b1;
    step();
    flush = 1'b0;
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd2(5'd3, 5'd3);
    chk("fl_we", 32'(reg_we_wb), 32'd0);
    chk("fl_r3", rs1_data, 32'h3333);
    chk("fl_cnt", 32'(retire_count), 32'd4);
    step();
    rd2(5'd3, 5'd0);
    chk("fl_r3_after", rs1_data, 32'h3333);
    chk("fl_cnt_after", 32'(retire_count), 32'd4);

    // Back-to-back writes to the same rd keep order.
    mem(1'b1, 1'b1, 5'd10, 32'h1); step();
    mem(1'b1, 1'b1, 5'd10, 32'h2); step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    rd2(5'd10, 5'd0);
    chk("b2b_byp", rs1_data, 32'h2);
    step();
    rd2(5'd10, 5'd0);
    chk("b2b_arr", rs1_data, 32'h2);
    chk("b2b_cnt", 32'(retire_count), 32'd6);

    // Reset during a stall loses the pending write.
    mem(1'b1, 1'b1, 5'd12, 32'h77); step();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    stall = 1'b1; rst = 1'b1; step();
    stall = 1'b0; rst = 1'b0;
    rd2(5'd12, 5'd10);
    chk("rstst_r12", rs1_data, 32'h0);
    chk("rstst_r10", rs2_data, 32'h0);
    chk("rstst_valid", 32'(valid_wb), 32'd0);
    step();
    rd2(5'd12, 5'd0);
    chk("rstst_r12b", rs1_data, 32'h0);

    // Counter wrap: 17 non-writing retirements on a 4-bit counter.
    rst = 1'b1; step(); rst = 1'b0;
    mem(1'b1, 1'b0, 5'd4, 32'hF0F0);
    for (int i = 0; i < 17; i++) step();
    chk("wrap_we_wb", 32'(reg_we_wb), 32'd0);
    chk("wrap_cnt16", 32'(retire_count), 32'd0);
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    step();
    rd2(5'd4, 5'd0);
    chk("wrap_cnt17", 32'(retire_count), 32'd1);
    chk("wrap_r4", rs1_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Receiving end of the register write-enable chain: the MEM/WB pipeline latch combined with the architectural register file it commits into.
- Captures the write-enable, destination and result from the MEM stage and performs the register write in the WB stage.
- Serves the decode-stage read ports with write-through bypass, and exports the WB-stage write for upstream forwarding.

Parameters:
- XLEN, 32, data width of registers and the result bus.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- AW, 5, register address width; must equal log2(NREG).
- CW, 32, width of the retire counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the WB slot; no commit, no capture.
- flush  in  1  replace the captured MEM-stage entry with a bubble.
- valid_mem  in  1  MEM stage holds a real instruction.
- reg_we_mem  in  1  MEM-stage register write-enable.
- rd_mem  in  AW  MEM-stage destination register.
- wdata_mem  in  XLEN  MEM-stage result.
- rs1_addr, rs2_addr  in  AW  decode read addresses.
- rs1_data, rs2_data  out  XLEN  read data, combinational.
- valid_wb  out  1  WB slot holds a real instruction.
- reg_we_wb  out  1  WB-stage write-enable, for the forwarding unit.
- rd_wb  out  AW  WB-stage destination.
- wdata_wb  out  XLEN  WB-stage result.
- retire_count  out  CW  number of instructions retired.

Behaviour:
- Reset (rst=1 at an edge, dominates everything):
  - valid_wb, reg_we_wb, rd_wb, wdata_wb and retire_count all become 0.
  - All NREG registers are cleared to 0 in that same single edge.
- Commit condition: commit = valid_wb & ~stall & ~rst.
- On a commit edge:
  - If reg_we_wb=1 and rd_wb!=0, register[rd_wb] <= wdata_wb.
  - retire_count increments by 1 and wraps modulo 2^CW.
  - A bubble (valid_wb=0) neither writes nor counts.
- Latch update, priority rst > stall > flush > capture:
  - stall=1: all WB outputs hold. stall dominates flush; the flush is the upstream controller's to re-assert.
  - flush=1 (no stall): valid_wb <= 0, reg_we_wb <= 0, rd_wb <= 0, wdata_wb <= 0.
  - Otherwise capture: valid_wb <= valid_mem, reg_we_wb <= reg_we_mem & valid_mem, rd_wb <= rd_mem, wdata_wb <= wdata_mem.
- Latency: MEM values appear on the WB outputs 1 edge after capture. The register array holds the value 2 edges after capture, absent stalls.
- Read ports (per port, combinational, no latency):
  - addr==0 reads 0.
  - Else, if valid_wb & reg_we_wb & rd_wb==addr, reads wdata_wb (write-through bypass, also applied while stalled).
  - Else reads register[addr].
- Both read ports may address the same register; each resolves independently.
- Writes to register 0 are discarded: no array update, no bypass. The commit still counts.
- Back-to-back writes to the same rd: the later capture overwrites wdata_wb, and the earlier value is committed on the intervening edge, so ordering is preserved.
- Reset mid-stall: reset wins and the pending write is lost.
- There is no asynchronous path anywhere in the block.

Decomposition:
- Shared package (pipe_pkg) holds:
  - XLEN, AW and NREG constants.
  - A wb_bundle_t struct {valid, we, rd, wdata}, shared with the other pipeline latch stages.
- Natural sub-module: regfile_2r1w. It holds the array with 2 combinational read ports, 1 write port, synchronous clear, x0 hardwiring and bypass.
- wb_regfile keeps the latch, the priority logic and the counter.

Test Plan:
- Reset: preload registers, then hold rst=1 for 1 cycle → all reads return 0, valid_wb=0, retire_count=0.
- Basic write: valid_mem=1, reg_we_mem=1, rd_mem=5, wdata_mem=0xDEADBEEF, no stall → rs1_addr=5 reads 0xDEADBEEF via bypass after edge 1 and from the array after edge 2; retire_count=1.
- x0 write: rd_mem=0, wdata_mem=0x1234, we=1 → rs1_addr=0 reads 0 at every cycle; retire_count still increments.
- Stall then flush: capture rd=7, data=0xA5; hold stall=1 for 3 cycles → register 7 is unwritten, the bypass returns 0xA5 and the count is frozen. Release the stall with flush=1 → register 7 = 0xA5 after that edge and valid_wb=0 on the next cycle.
- Flush without stall: MEM entry rd=3, data=0x55, then flush=1 → reg_we_wb=0; register 3 keeps its old value; the count is unchanged for the bubble.
- Counter wrap: set CW=4 and retire 17 valid instructions → retire_count=1.
